// File: rtl/ula_io_if.sv
// ula_io_if -- CPU-side I/O bus between the Z80 core and the ULA port block.
// The master modport is the CPU (or a bench driving it), the slave modport is
// the ULA port decoder, which returns read data and a read-select flag.
interface ula_io_if;
  logic [15:0] addr;
  logic        n_iorq;
  logic        n_wr;
  logic        n_rd;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd_sel;

  modport master (
    output addr, n_iorq, n_wr, n_rd, din,
    input  dout, rd_sel
  );

  modport slave (
    input  addr, n_iorq, n_wr, n_rd, din,
    output dout, rd_sel
  );
endinterface

// File: rtl/ula_io.sv
// ula_io -- ULA port 0xFE: border/MIC/beeper write latch, keyboard/EAR read,
// beeper-activity LED stretcher and 1-bit audio output.
// Optional feature macro ULA_IO_DAC_EN: when defined, audio_pdm comes from a
// DAC_W-bit first-order sigma-delta modulator mixing speaker and MIC levels;
// when undefined, audio_pdm is simply the speaker bit delayed by one clock.
module ula_io #(
  parameter int DAC_W = 8,
  parameter int ACT_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  ula_io_if.slave    bus,
  input  logic [4:0] key_data,
  input  logic       ear_in,
  output logic [2:0] border,
  output logic       mic,
  output logic       speaker,
  output logic       audio_pdm,
  output logic       activity
);

  logic             sel;
  logic             wr_n_c;
  logic             wr_q;
  logic             wr_armed;
  logic             write_det;
  logic             ear_s1;
  logic             ear_s;
  logic [ACT_W-1:0] act_cnt;
  logic             unused_bits;

  // Only addr[0] decodes the port; the upper address bits and din[7:5] are
  // deliberately ignored, as on the original machine.
  assign sel         = ~bus.n_iorq & ~bus.addr[0];
  assign wr_n_c      = bus.n_iorq | bus.n_wr | bus.addr[0];
  assign write_det   = ~wr_n_c & wr_q & wr_armed;
  assign bus.rd_sel  = sel & ~bus.n_rd;
  assign bus.dout    = bus.rd_sel ? {1'b1, ear_s, 1'b1, key_data} : 8'hFF;
  assign activity    = (act_cnt != '0);
  assign unused_bits = ^{bus.addr[15:1], bus.din[7:5]};

  // Falling-edge detector on the write strobe. wr_armed stays low after reset
  // until the strobe has been seen high, so an access already in progress when
  // reset releases can never be mistaken for a fresh write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q     <= 1'b1;
      wr_armed <= 1'b0;
    end else begin
      wr_q <= wr_n_c;
      if (wr_n_c) begin
        wr_armed <= 1'b1;
      end
    end
  end

  // Port 0xFE output latch, loaded once per write access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      border  <= 3'b000;
      mic     <= 1'b0;
      speaker <= 1'b0;
    end else if (write_det) begin
      border  <= bus.din[2:0];
      mic     <= bus.din[3];
      speaker <= bus.din[4];
    end
  end

  // Two-flop synchronizer for the asynchronous tape EAR input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ear_s1 <= 1'b0;
      ear_s  <= 1'b0;
    end else begin
      ear_s1 <= ear_in;
      ear_s  <= ear_s1;
    end
  end

  // Activity stretcher: every beeper toggle (re)loads all-ones, then it counts down to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_cnt <= '0;
    end else if (write_det && (bus.din[4] != speaker)) begin
      act_cnt <= '1;
    end else if (act_cnt != '0) begin
      act_cnt <= act_cnt - {{(ACT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ULA_IO_DAC_EN
  // Speaker contributes 3/4 of full scale, MIC 1/4; both together reach
  // exactly 2^DAC_W, which is clamped to all-ones so it never wraps to silence.
  localparam logic [DAC_W:0] SPK_LVL = {1'b0, 2'b11, {(DAC_W-2){1'b0}}};
  localparam logic [DAC_W:0] MIC_LVL = {2'b00, 1'b1, {(DAC_W-2){1'b0}}};

  logic [DAC_W:0]   level_sum;
  logic [DAC_W-1:0] level;
  logic [DAC_W-1:0] acc;
  logic [DAC_W:0]   acc_sum;

  // Mix the two sources into a saturated level and form the next accumulator sum.
  always_comb begin
    level_sum = '0;
    if (speaker) begin
      level_sum = level_sum + SPK_LVL;
    end
    if (mic) begin
      level_sum = level_sum + MIC_LVL;
    end
    level   = level_sum[DAC_W] ? {DAC_W{1'b1}} : level_sum[DAC_W-1:0];
    acc_sum = {1'b0, acc} + {1'b0, level};
  end

  // First-order sigma-delta: the registered carry is the pulse-density output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      audio_pdm <= 1'b0;
    end else begin
      acc       <= acc_sum[DAC_W-1:0];
      audio_pdm <= acc_sum[DAC_W];
    end
  end
`else
  // Plain beeper output: the speaker bit delayed by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_pdm <= 1'b0;
    end else begin
      audio_pdm <= speaker;
    end
  end
`endif

endmodule

// File: tb/tb_ula_io.sv
// tb_ula_io -- directed self-checking bench for ula_io (DAC_W=8, ACT_W=4).
module tb_ula_io;

  logic       clk;
  logic       reset_n;
  logic [4:0] key_data;
  logic       ear_in;
  logic [2:0] border;
  logic       mic;
  logic       speaker;
  logic       audio_pdm;
  logic       activity;

  int errors = 0;
  int checks = 0;

  ula_io_if bus ();

  ula_io #(
    .DAC_W(8),
    .ACT_W(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .key_data (key_data),
    .ear_in   (ear_in),
    .border   (border),
    .mic      (mic),
    .speaker  (speaker),
    .audio_pdm(audio_pdm),
    .activity (activity)
  );

  // 25 MHz pixel clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.n_iorq = 1'b1;
    bus.n_wr   = 1'b1;
    bus.n_rd   = 1'b1;
    bus.addr   = 16'h00FE;
  endtask

  // One-clock write access; returns just after the latching edge with the strobe released.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr   = a;
    bus.din    = d;
    bus.n_iorq = 1'b0;
    bus.n_wr   = 1'b0;
    tick(1);
    bus.n_iorq = 1'b1;
    bus.n_wr   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    key_data = 5'b11111;
    ear_in   = 1'b0;
    bus.din  = 8'h00;
    idle_bus();
    #5;
    checks++; if (border !== 3'b000) begin errors++; $display("[TB] FAIL reset_border: got %b expected 000", border); end
    checks++; if (mic !== 1'b0) begin errors++; $display("[TB] FAIL reset_mic: got %b expected 0", mic); end
    checks++; if (speaker !== 1'b0) begin errors++; $display("[TB] FAIL reset_speaker: got %b expected 0", speaker); end
    checks++; if (audio_pdm !== 1'b0) begin errors++; $display("[TB] FAIL reset_pdm: got %b expected 0", audio_pdm); end
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL reset_activity: got %b expected 0", activity); end
    checks++; if (bus.dout !== 8'hFF) begin errors++; $display("[TB] FAIL reset_dout: got %h expected ff", bus.dout); end
    checks++; if (bus.rd_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_sel: got %b expected 0", bus.rd_sel); end
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_write_hold();
    bus.addr   = 16'h00FE;
    bus.din    = 8'h15;
    bus.n_iorq = 1'b0;
    bus.n_wr   = 1'b0;
    tick(1);
    checks++; if (border !== 3'b101) begin errors++; $display("[TB] FAIL hold_border: got %b expected 101", border); end
    checks++; if (speaker !== 1'b1) begin errors++; $display("[TB] FAIL hold_speaker: got %b expected 1", speaker); end
    checks++; if (mic !== 1'b0) begin errors++; $display("[TB] FAIL hold_mic: got %b expected 0", mic); end
    // a second latch during the held access would pick up this new data
    bus.din = 8'h02;
    tick(11);
    checks++; if (border !== 3'b101) begin errors++; $display("[TB] FAIL hold_single_border: got %b expected 101", border); end
    checks++; if (speaker !== 1'b1) begin errors++; $display("[TB] FAIL hold_single_speaker: got %b expected 1", speaker); end
    idle_bus();
    tick(2);
  endtask

  task automatic test_addr_decode();
    bus.addr   = 16'h00FF;
    bus.din    = 8'h07;
    bus.n_iorq = 1'b0;
    bus.n_wr   = 1'b0;
    tick(2);
    idle_bus();
    tick(1);
    checks++; if (border !== 3'b101) begin errors++; $display("[TB] FAIL odd_addr_write: got %b expected 101", border); end
    // upper address bits and din[7:5] ignored
    do_write(16'hA5FE, 8'hF3);
    checks++; if (border !== 3'b011) begin errors++; $display("[TB] FAIL upper_addr_border: got %b expected 011", border); end
    checks++; if (mic !== 1'b0) begin errors++; $display("[TB] FAIL upper_addr_mic: got %b expected 0", mic); end
    checks++; if (speaker !== 1'b1) begin errors++; $display("[TB] FAIL upper_addr_speaker: got %b expected 1", speaker); end
    tick(1);
    bus.addr   = 16'h7FFE;
    key_data   = 5'b10110;
    ear_in     = 1'b1;
    bus.n_iorq = 1'b0;
    bus.n_rd   = 1'b0;
    #1;
    checks++; if (bus.rd_sel !== 1'b1) begin errors++; $display("[TB] FAIL read_rd_sel: got %b expected 1", bus.rd_sel); end
    checks++; if (bus.dout !== 8'hB6) begin errors++; $display("[TB] FAIL read_ear_0clk: got %h expected b6", bus.dout); end
    tick(1);
    checks++; if (bus.dout !== 8'hB6) begin errors++; $display("[TB] FAIL read_ear_1clk: got %h expected b6", bus.dout); end
    tick(1);
    checks++; if (bus.dout !== 8'hF6) begin errors++; $display("[TB] FAIL read_ear_2clk: got %h expected f6", bus.dout); end
    tick(1);
    checks++; if (bus.dout !== 8'hF6) begin errors++; $display("[TB] FAIL read_3clk: got %h expected f6", bus.dout); end
    bus.n_rd = 1'b1;
    #1;
    checks++; if (bus.dout !== 8'hFF) begin errors++; $display("[TB] FAIL read_release_dout: got %h expected ff", bus.dout); end
    checks++; if (bus.rd_sel !== 1'b0) begin errors++; $display("[TB] FAIL read_release_sel: got %b expected 0", bus.rd_sel); end
    bus.addr = 16'h7FFF;
    bus.n_rd = 1'b0;
    #1;
    checks++; if (bus.dout !== 8'hFF) begin errors++; $display("[TB] FAIL read_odd_dout: got %h expected ff", bus.dout); end
    idle_bus();
    tick(1);
  endtask

  task automatic test_activity();
    int hi;
    tick(20);
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL act_drained: got %b expected 0", activity); end
    do_write(16'h00FE, 8'h00);
    tick(20);
    checks++; if (speaker !== 1'b0) begin errors++; $display("[TB] FAIL act_speaker_off: got %b expected 0", speaker); end
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL act_idle: got %b expected 0", activity); end
    do_write(16'h00FE, 8'h10);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (activity === 1'b1) hi++;
      tick(1);
    end
    checks++; if (hi != 15) begin errors++; $display("[TB] FAIL act_stretch: got %0d high clks expected 15", hi); end
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL act_expired: got %b expected 0", activity); end
    // same speaker value again: no toggle, no reload
    do_write(16'h00FE, 8'h10);
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL act_no_reload: got %b expected 0", activity); end
    tick(2);
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL act_no_reload_late: got %b expected 0", activity); end
    // toggle while the counter is still running reloads it
    do_write(16'h00FE, 8'h00);
    tick(5);
    do_write(16'h00FE, 8'h10);
    tick(14);
    checks++; if (activity !== 1'b1) begin errors++; $display("[TB] FAIL act_reload_hold: got %b expected 1", activity); end
    tick(1);
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL act_reload_end: got %b expected 0", activity); end
  endtask

  task automatic test_audio();
`ifdef ULA_IO_DAC_EN
    int hi;
    logic [7:0] pat [4];
    int         exp_hi [4];
    pat[0] = 8'h10; exp_hi[0] = 192;
    pat[1] = 8'h18; exp_hi[1] = 255;
    pat[2] = 8'h08; exp_hi[2] = 64;
    pat[3] = 8'h00; exp_hi[3] = 0;
    for (int p = 0; p < 4; p++) begin
      tick(1);
      do_write(16'h00FE, pat[p]);
      tick(3);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        tick(1);
        if (audio_pdm === 1'b1) hi++;
      end
      checks++;
      if (hi != exp_hi[p]) begin
        errors++;
        $display("[TB] FAIL pdm_density din=%h: got %0d highs expected %0d", pat[p], hi, exp_hi[p]);
      end
    end
`else
    tick(1);
    do_write(16'h00FE, 8'h00);
    tick(3);
    checks++; if (audio_pdm !== 1'b0) begin errors++; $display("[TB] FAIL pdm_idle: got %b expected 0", audio_pdm); end
    do_write(16'h00FE, 8'h10);
    checks++; if (audio_pdm !== 1'b0) begin errors++; $display("[TB] FAIL pdm_rise_early: got %b expected 0", audio_pdm); end
    tick(1);
    checks++; if (audio_pdm !== 1'b1) begin errors++; $display("[TB] FAIL pdm_rise: got %b expected 1", audio_pdm); end
    tick(1);
    do_write(16'h00FE, 8'h00);
    checks++; if (audio_pdm !== 1'b1) begin errors++; $display("[TB] FAIL pdm_fall_early: got %b expected 1", audio_pdm); end
    tick(1);
    checks++; if (audio_pdm !== 1'b0) begin errors++; $display("[TB] FAIL pdm_fall: got %b expected 0", audio_pdm); end
`endif
    tick(2);
  endtask

  task automatic test_reset_mid_access();
    bus.addr   = 16'h00FE;
    bus.din    = 8'h07;
    bus.n_iorq = 1'b0;
    bus.n_wr   = 1'b0;
    tick(1);
    checks++; if (border !== 3'b111) begin errors++; $display("[TB] FAIL mid_pre_border: got %b expected 111", border); end
    #5;
    reset_n = 1'b0;
    #1;
    checks++; if (border !== 3'b000) begin errors++; $display("[TB] FAIL mid_async_clear: got %b expected 000", border); end
    tick(2);
    reset_n = 1'b1;
    tick(3);
    checks++; if (border !== 3'b000) begin errors++; $display("[TB] FAIL mid_no_latch: got %b expected 000", border); end
    checks++; if (activity !== 1'b0) begin errors++; $display("[TB] FAIL mid_activity: got %b expected 0", activity); end
    idle_bus();
    tick(2);
    do_write(16'h00FE, 8'h0D);
    checks++; if (border !== 3'b101) begin errors++; $display("[TB] FAIL mid_clean_border: got %b expected 101", border); end
    checks++; if (mic !== 1'b1) begin errors++; $display("[TB] FAIL mid_clean_mic: got %b expected 1", mic); end
    tick(2);
  endtask

  initial begin
    $display("[TB] starting ula_io bench");
    test_reset();
    test_write_hold();
    test_addr_decode();
    test_activity();
    test_audio();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
